// File: rtl/thresh_share_arb.sv
// -----------------------------------------------------------------------------
// thresh_share_arb
//
// Time-shares one adaptive-threshold datapath among N_CH pixel streams.
// A round-robin arbiter picks one requesting channel per cycle. The shared
// update then runs against that channel's running-mean accumulator, taken from
// a per-channel context bank. The result (flag, mean, channel id) is registered,
// so it appears one cycle after the beat is accepted.
//
// Parameters
//   N_CH   : number of channels (2..8)
//   CHW    : channel id width, clog2(N_CH)
//   SHIFT  : IIR shift, alpha = 2^-SHIFT; accumulator width AW = 8 + SHIFT
//   OFFSET : threshold offset added to the mean (0..255)
//
// Ports
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset
//   ch_en  in   [N_CH]    per-channel enable; a disabled channel is never granted
//   s_vld  in   [N_CH]    per-channel pixel valid
//   s_sof  in   [N_CH]    per-channel start-of-frame, qualified by the beat
//   s_pix  in   [8*N_CH]  per-channel pixel, channel i at [8i+7:8i]
//   s_rdy  out  [N_CH]    one-hot grant; a beat moves on s_vld[i] & s_rdy[i]
//   m_vld  out            result valid
//   m_rdy  in             downstream ready
//   m_ch   out  [CHW]     channel id of the result
//   m_flag out            pixel above (mean + OFFSET)
//   m_mean out  [8]       mean used for the compare
// -----------------------------------------------------------------------------
module thresh_share_arb #(
    parameter int N_CH   = 4,
    parameter int CHW    = $clog2(N_CH),
    parameter int SHIFT  = 8,
    parameter int OFFSET = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_CH-1:0]     ch_en,
    input  logic [N_CH-1:0]     s_vld,
    input  logic [N_CH-1:0]     s_sof,
    input  logic [8*N_CH-1:0]   s_pix,
    output logic [N_CH-1:0]     s_rdy,
    output logic                m_vld,
    input  logic                m_rdy,
    output logic [CHW-1:0]      m_ch,
    output logic                m_flag,
    output logic [7:0]          m_mean
);

    localparam int AW = 8 + SHIFT;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CHW-1:0]            ptr_q,    ptr_d;
    logic                      m_vld_q,  m_vld_d;
    logic [CHW-1:0]            m_ch_q,   m_ch_d;
    logic                      m_flag_q, m_flag_d;
    logic [7:0]                m_mean_q, m_mean_d;

    // Flat view of every channel's accumulator so the granted one can be
    // selected with a plain index.
    logic [N_CH-1:0][AW-1:0]   acc_all;
    logic [N_CH-1:0][7:0]      pix_arr;

    assign pix_arr = s_pix;

    // ------------------------------------------------------------------
    // Arbiter
    // ------------------------------------------------------------------
    logic [N_CH-1:0] req;
    logic            can_accept;
    logic            gnt_found;
    logic [CHW-1:0]  gnt_idx;
    logic            xfer;

    assign req        = s_vld & ch_en;
    // The output register can take a new result if it is empty or is being
    // drained this cycle; this gives the bubble-free handoff after backpressure.
    assign can_accept = !m_vld_q || m_rdy;

    // Search begins one past the last winner and wraps, so the most recently
    // served channel has the lowest priority.
    always_comb begin
        int             idx;
        logic [CHW-1:0] idx_c;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        idx_c     = '0;
        for (int k = 1; k <= N_CH; k++) begin
            idx   = (int'(ptr_q) + k) % N_CH;
            idx_c = CHW'(idx);
            if (!gnt_found && req[idx_c]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx_c;
            end
        end
    end

    assign xfer = can_accept && gnt_found;

    // One-hot grant. A bit is only set on a requesting channel, so s_rdy
    // equals the set of beats that actually transfer.
    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_rdy
            assign s_rdy[gi] = xfer && (gnt_idx == CHW'(gi));
        end
    endgenerate

    // ------------------------------------------------------------------
    // Shared threshold datapath
    // ------------------------------------------------------------------
    logic [7:0]    sel_pix;
    logic          sel_sof;
    logic [AW-1:0] sel_acc;
    logic [7:0]    sel_mean;
    logic [8:0]    sel_thr;
    logic          sel_flag;
    logic [AW-1:0] acc_upd;

    assign sel_pix  = pix_arr[gnt_idx];
    assign sel_sof  = s_sof[gnt_idx];
    assign sel_acc  = acc_all[gnt_idx];
    assign sel_mean = sel_acc[AW-1:SHIFT];

    // Threshold in 9 bits so mean + OFFSET cannot wrap past 255.
    assign sel_thr  = {1'b0, sel_mean} + 9'(OFFSET);
    assign sel_flag = ({1'b0, sel_pix} > sel_thr);

    // The IIR update acc += p - mean is bounded by 255 << SHIFT in steady
    // state, so the modular AW-bit sum never actually wraps.
    assign acc_upd = sel_sof ? {sel_pix, {SHIFT{1'b0}}}
                             : sel_acc + AW'(sel_pix) - AW'(sel_mean);

    // ------------------------------------------------------------------
    // Context bank: one accumulator per channel. Only the granted
    // channel's entry is written.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ctx
            logic [AW-1:0] acc_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    acc_q <= '0;
                end else if (s_rdy[gi]) begin
                    acc_q <= acc_upd;
                end
            end

            assign acc_all[gi] = acc_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Pointer and output register next-state
    // ------------------------------------------------------------------
    always_comb begin
        ptr_d    = ptr_q;
        m_vld_d  = m_vld_q;
        m_ch_d   = m_ch_q;
        m_flag_d = m_flag_q;
        m_mean_d = m_mean_q;
        if (xfer) begin
            ptr_d    = gnt_idx;
            m_vld_d  = 1'b1;
            m_ch_d   = gnt_idx;
            m_flag_d = sel_sof ? 1'b0 : sel_flag;
            m_mean_d = sel_sof ? sel_pix : sel_mean;
        end else if (m_rdy) begin
            // Only valid is cleared on a drain; the payload keeps its value.
            m_vld_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // N_CH-1 makes channel 0 the first winner after reset.
            ptr_q    <= CHW'(N_CH - 1);
            m_vld_q  <= 1'b0;
            m_ch_q   <= '0;
            m_flag_q <= 1'b0;
            m_mean_q <= '0;
        end else begin
            ptr_q    <= ptr_d;
            m_vld_q  <= m_vld_d;
            m_ch_q   <= m_ch_d;
            m_flag_q <= m_flag_d;
            m_mean_q <= m_mean_d;
        end
    end

    assign m_vld  = m_vld_q;
    assign m_ch   = m_ch_q;
    assign m_flag = m_flag_q;
    assign m_mean = m_mean_q;

endmodule

// File: tb/tb_thresh_share_arb.sv
// -----------------------------------------------------------------------------
// tb_thresh_share_arb
//
// Drives directed and random traffic into thresh_share_arb. A behavioural
// model (integer accumulators, round-robin pointer) predicts each grant and
// each result. Every predicted result is queued. A separate monitor pops the
// queue whenever the DUT hands a result downstream and compares the two.
// -----------------------------------------------------------------------------
module tb_thresh_share_arb;

    localparam int N      = 4;
    localparam int CHW    = 2;
    localparam int SHIFT  = 8;
    localparam int OFFSET = 8;
    localparam int AW     = 8 + SHIFT;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     ch_en;
    logic [N-1:0]     s_vld;
    logic [N-1:0]     s_sof;
    logic [8*N-1:0]   s_pix;
    logic [N-1:0]     s_rdy;
    logic             m_vld;
    logic             m_rdy;
    logic [CHW-1:0]   m_ch;
    logic             m_flag;
    logic [7:0]       m_mean;

    thresh_share_arb #(
        .N_CH   (N),
        .CHW    (CHW),
        .SHIFT  (SHIFT),
        .OFFSET (OFFSET)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ch_en  (ch_en),
        .s_vld  (s_vld),
        .s_sof  (s_sof),
        .s_pix  (s_pix),
        .s_rdy  (s_rdy),
        .m_vld  (m_vld),
        .m_rdy  (m_rdy),
        .m_ch   (m_ch),
        .m_flag (m_flag),
        .m_mean (m_mean)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CHW-1:0] ch;
        logic           flag;
        logic [7:0]     mean;
    } res_t;

    res_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    int   model_acc[N];
    int   model_ptr;
    bit   model_mv;

    function automatic void model_reset();
        for (int i = 0; i < N; i++) model_acc[i] = 0;
        model_ptr = N - 1;
        model_mv  = 1'b0;
    endfunction

    function automatic logic [8*N-1:0] pk(input int a, input int b, input int c, input int d);
        logic [8*N-1:0] v;
        v = {8'(d), 8'(c), 8'(b), 8'(a)};
        return v;
    endfunction

    // One clock cycle: apply inputs, predict the grant from the model, check
    // s_rdy, and if a beat is expected to transfer, queue its result.
    task automatic step(input logic [N-1:0] en, input logic [N-1:0] vld,
                        input logic [N-1:0] sof, input logic [8*N-1:0] pix,
                        input logic rdy);
        logic [N-1:0] req;
        logic [N-1:0] exp_rdy;
        int           g;
        int           p;
        int           mean;
        res_t         r;
        @(posedge clk);
        #1;
        ch_en = en;
        s_vld = vld;
        s_sof = sof;
        s_pix = pix;
        m_rdy = rdy;
        req     = vld & en;
        exp_rdy = '0;
        g       = -1;
        if ((!model_mv || rdy) && req != '0) begin
            for (int k = 1; k <= N; k++) begin
                if (g < 0 && req[(model_ptr + k) % N]) g = (model_ptr + k) % N;
            end
            exp_rdy[g] = 1'b1;
        end
        #1;
        checks++;
        if (s_rdy !== exp_rdy)
            $display("FAIL s_rdy got %b want %b", s_rdy, exp_rdy);
        if (s_rdy !== exp_rdy) errors++;
        if (g >= 0) begin
            p    = int'(pix[g*8 +: 8]);
            mean = model_acc[g] >> SHIFT;
            r.ch = CHW'(g);
            if (sof[g]) begin
                r.flag       = 1'b0;
                r.mean       = 8'(p);
                model_acc[g] = p << SHIFT;
            end else begin
                r.flag       = (p > mean + OFFSET);
                r.mean       = 8'(mean);
                model_acc[g] = (model_acc[g] + p - mean) & ((1 << AW) - 1);
            end
            exp_q.push_back(r);
            model_ptr = g;
            model_mv  = 1'b1;
        end else if (rdy) begin
            model_mv = 1'b0;
        end
    endtask

    // Monitor: compares each result as it is consumed, and checks that a
    // stalled result does not change while it waits.
    initial begin
        bit   hold;
        res_t held;
        res_t got;
        res_t want;
        hold = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            got = {m_ch, m_flag, m_mean};
            if (rst_n && hold && m_vld) begin
                checks++;
                if (got !== held) begin
                    errors++;
                    $display("FAIL stall_stable got %h want %h", got, held);
                end
            end
            if (rst_n && m_vld && m_rdy) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL result unexpected ch %0d flag %0d mean %0d", m_ch, m_flag, m_mean);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        errors++;
                        $display("FAIL result got ch %0d flag %0d mean %0d want ch %0d flag %0d mean %0d",
                                 got.ch, got.flag, got.mean, want.ch, want.flag, want.mean);
                    end
                end
            end
            hold = rst_n && m_vld && !m_rdy;
            held = got;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        ch_en = '0;
        s_vld = '0;
        s_sof = '0;
        s_pix = '0;
        m_rdy = 1'b1;
        model_reset();

        // Reset and idle
        repeat (3) begin
            @(posedge clk);
            #1;
            checks++;
            if (m_vld !== 1'b0 || s_rdy !== '0) begin
                errors++;
                $display("FAIL in_reset m_vld %b s_rdy %b want 0 0000", m_vld, s_rdy);
            end
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if ({m_vld, m_ch, m_flag, m_mean} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %b %0d %b %0d want all 0", m_vld, m_ch, m_flag, m_mean);
        end
        repeat (2) step(4'hF, 4'h0, 4'h0, '0, 1'b1);

        // First grant with all requesting goes to channel 0
        step(4'hF, 4'hF, 4'hF, pk(10, 20, 30, 40), 1'b1);

        // Single channel threshold compare
        step(4'hF, 4'h1, 4'h1, pk(100, 0, 0, 0), 1'b1);
        step(4'hF, 4'h1, 4'h0, pk(120, 0, 0, 0), 1'b1);
        step(4'hF, 4'h1, 4'h0, pk(108, 0, 0, 0), 1'b1);
        step(4'hF, 4'h1, 4'h0, pk(109, 0, 0, 0), 1'b1);

        // Round robin, then channel 2 disabled
        repeat (12) step(4'hF, 4'hF, 4'h0, pk($urandom_range(0, 255), $urandom_range(0, 255),
                                               $urandom_range(0, 255), $urandom_range(0, 255)), 1'b1);
        repeat (9) step(4'hB, 4'hF, 4'h0, pk(50, 60, 70, 80), 1'b1);

        // Backpressure with ch1 and ch3 valid
        step(4'hF, 4'hA, 4'h0, pk(0, 33, 0, 44), 1'b1);
        repeat (3) step(4'hF, 4'hA, 4'h0, pk(0, 33, 0, 44), 1'b0);
        repeat (4) step(4'hF, 4'hA, 4'h0, pk(0, 33, 0, 44), 1'b1);

        // Context isolation
        step(4'hF, 4'h1, 4'h1, pk(200, 0, 0, 0), 1'b1);
        step(4'hF, 4'h2, 4'h2, pk(0, 20, 0, 0), 1'b1);
        repeat (100) step(4'hF, 4'h3, 4'h0, pk(200, 20, 0, 0), 1'b1);
        step(4'hF, 4'h2, 4'h0, pk(0, 29, 0, 0), 1'b1);
        step(4'hF, 4'h2, 4'h0, pk(0, 28, 0, 0), 1'b1);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic [N-1:0] sof_r;
            for (int i = 0; i < N; i++) sof_r[i] = ($urandom_range(0, 7) == 0);
            step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), sof_r,
                 pk($urandom_range(0, 255), $urandom_range(0, 255),
                    $urandom_range(0, 255), $urandom_range(0, 255)),
                 ($urandom_range(0, 3) != 0));
        end
        repeat (3) step(4'hF, 4'h0, 4'h0, '0, 1'b1);

        // Reset in the middle of a ch2 stream
        step(4'hF, 4'h4, 4'h4, pk(0, 0, 50, 0), 1'b1);
        repeat (3) step(4'hF, 4'h4, 4'h0, pk(0, 0, 60, 0), 1'b1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        s_vld = '0;
        #1;
        checks++;
        if (m_vld !== 1'b0 || m_mean !== 8'd0) begin
            errors++;
            $display("FAIL async_reset m_vld %b m_mean %0d want 0 0", m_vld, m_mean);
        end
        exp_q.delete();
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        step(4'hF, 4'h4, 4'h0, pk(0, 0, 9, 0), 1'b1);

        // Drain and confirm every predicted result was seen
        repeat (3) step(4'hF, 4'h0, 4'h0, '0, 1'b1);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d want 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
